// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle RV64 subset controller:
// state encodings, opcode constants and the opcode legality check.
package core_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int WAIT_W = 16;

    // True for opcodes that go on to EXEC; ecall is handled separately
    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction and data memory request/ready handshake bundle.
interface multicycle_ctrl_if;

    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ready, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ready, dmem_ready
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter shared by the fetch and data-memory phases;
// flags expiry once MEM_TIMEOUT unanswered request cycles have passed.
module mem_wait_timer
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MEM_TIMEOUT);

    logic [WAIT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: fetch/decode/exec/mem/wb for add/sub/and/or,
// ld, sd, beq; halts on ecall, illegal opcode or memory timeout.
module multicycle_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       opcode,
    input  logic             MemWrite,
    input  logic             Zero,
    multicycle_ctrl_if.master mem,
    output logic             IRWrite,
    output logic             ExtRegWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       state
);

    state_t state_q;
    state_t state_d;

    logic imem_req;
    logic dmem_req;
    logic dmem_we;
    logic retire;
    logic set_err;
    logic wait_req;
    logic wait_rdy;
    logic expired;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (state_d != state_q),
        .en     (wait_req && !wait_rdy),
        .expired(expired)
    );

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        IRWrite     = 1'b0;
        ExtRegWrite = 1'b0;
        PCWrite     = 1'b0;
        PCSrc       = 1'b0;
        retire      = 1'b0;
        set_err     = 1'b0;
        wait_req    = 1'b0;
        wait_rdy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                wait_req = 1'b1;
                wait_rdy = mem.imem_ready;
                // ready on the expiry cycle still counts as progress
                if (mem.imem_ready) begin
                    IRWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (expired) begin
                    set_err = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    (opcode == OP_SYSTEM): state_d = S_HALT;
                    is_legal(opcode):      state_d = S_EXEC;
                    default: begin
                        set_err = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_EXEC: begin
                unique case (1'b1)
                    (opcode == OP_RTYPE): state_d = S_WB;
                    (opcode == OP_LOAD),
                    (opcode == OP_STORE): state_d = S_MEM;
                    (opcode == OP_BRANCH): begin
                        PCWrite = 1'b1;
                        PCSrc   = Zero;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: begin
                        set_err = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = MemWrite;
                wait_req = 1'b1;
                wait_rdy = mem.dmem_ready;
                if (mem.dmem_ready) begin
                    if (opcode == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        PCWrite = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (expired) begin
                    set_err = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                ExtRegWrite = 1'b1;
                PCWrite     = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                set_err = 1'b1;
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            error       <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (set_err) error <= 1'b1;
            if (retire && instr_count != '1) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    assign mem.imem_req = imem_req;
    assign mem.dmem_req = dmem_req;
    assign mem.dmem_we  = dmem_we;
    assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted = (state_q == S_HALT);
    assign state  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle plans
// built from the sequencing rules, with randomized waits and programs.
module tb_multicycle_ctrl;

    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] LD   = 7'b0000011;
    localparam logic [6:0] SD   = 7'b0100011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] ECALL = 7'b1110011;
    localparam logic [6:0] ADDI = 7'b0010011;

    logic clk;
    logic reset;
    logic start;
    logic [6:0] opcode;
    logic MemWrite;
    logic Zero;
    logic imem_ready;
    logic dmem_ready;

    logic ir, rw, pcw, pcsrc, busy, halted, error;
    logic [31:0] cnt;
    logic [2:0] st;
    logic ir3, rw3, pcw3, pcsrc3, busy3, halted3, error3;
    logic [2:0] cnt3;
    logic [2:0] st3;

    multicycle_ctrl_if mif ();
    multicycle_ctrl_if mif3 ();

    assign mif.imem_ready  = imem_ready;
    assign mif.dmem_ready  = dmem_ready;
    assign mif3.imem_ready = imem_ready;
    assign mif3.dmem_ready = dmem_ready;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .opcode(opcode), .MemWrite(MemWrite), .Zero(Zero),
        .mem(mif), .IRWrite(ir), .ExtRegWrite(rw),
        .PCWrite(pcw), .PCSrc(pcsrc), .busy(busy),
        .halted(halted), .error(error),
        .instr_count(cnt), .state(st)
    );

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .start(start),
        .opcode(opcode), .MemWrite(MemWrite), .Zero(Zero),
        .mem(mif3), .IRWrite(ir3), .ExtRegWrite(rw3),
        .PCWrite(pcw3), .PCSrc(pcsrc3), .busy(busy3),
        .halted(halted3), .error(error3),
        .instr_count(cnt3), .state(st3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic ir, pcw, pcsrc, rw;
        logic ireq, dreq, dwe;
        logic busy, halted;
    } obs_t;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;

    obs_t plan_q[$];
    bit   ird_q[$];
    bit   drd_q[$];

    function automatic obs_t mk(int s, bit i_w, bit p_w, bit p_s,
                                bit r_w, bit i_r, bit d_r, bit d_w);
        obs_t o;
        o.st     = 3'(s);
        o.ir     = i_w;
        o.pcw    = p_w;
        o.pcsrc  = p_s;
        o.rw     = r_w;
        o.ireq   = i_r;
        o.dreq   = d_r;
        o.dwe    = d_w;
        o.busy   = (s != 0) && (s != 6);
        o.halted = (s == 6);
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o = {st, ir, pcw, pcsrc, rw, mif.imem_req,
             mif.dmem_req, mif.dmem_we, busy, halted};
        return o;
    endfunction

    function automatic bit runs(input logic [6:0] op);
        return op == ADD || op == LD || op == SD || op == BEQ;
    endfunction

    function automatic int sat3(input int c);
        return (c > 7) ? 7 : c;
    endfunction

    // Expected per-cycle picture of one instruction, starting at FETCH
    task automatic build(input logic [6:0] op, input bit mw,
                         input bit z, input int iw, input int dw);
        plan_q.delete();
        ird_q.delete();
        drd_q.delete();
        for (int i = 0; i <= iw; i++) begin
            plan_q.push_back(mk(1, i == iw, 0, 0, 0, 1, 0, 0));
            ird_q.push_back(i == iw);
            drd_q.push_back(1'b0);
        end
        plan_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0));
        ird_q.push_back(1'b0);
        drd_q.push_back(1'b0);
        if (!runs(op)) return;
        if (op == BEQ) plan_q.push_back(mk(3, 0, 1, z, 0, 0, 0, 0));
        else plan_q.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0));
        ird_q.push_back(1'b0);
        drd_q.push_back(1'b0);
        if (op == LD || op == SD) begin
            for (int i = 0; i <= dw; i++) begin
                plan_q.push_back(
                    mk(4, 0, op == SD && i == dw, 0, 0, 0, 1, mw));
                ird_q.push_back(1'b0);
                drd_q.push_back(i == dw);
            end
        end
        if (op == ADD || op == LD) begin
            plan_q.push_back(mk(5, 0, 1, 0, 1, 0, 0, 0));
            ird_q.push_back(1'b0);
            drd_q.push_back(1'b0);
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input bit mw,
                             input bit z, input int iw, input int dw,
                             input string name);
        obs_t got;
        bit exp_err;
        logic [2:0] exp_st;
        build(op, mw, z, iw, dw);
        opcode = op;
        MemWrite = mw;
        Zero = z;
        foreach (plan_q[k]) begin
            imem_ready = ird_q[k];
            dmem_ready = drd_q[k];
            start = 1'($urandom_range(0, 1));
            #1;
            got = observe();
            checks++;
            if (got !== plan_q[k]) begin
                errors++;
                $display("FAIL %s cyc%0d got=%b exp=%b",
                         name, k, got, plan_q[k]);
            end
            @(posedge clk);
            #1;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        start = 1'b0;
        if (runs(op)) exp_count++;
        exp_err = !runs(op) && op != ECALL;
        exp_st = runs(op) ? 3'd1 : 3'd6;
        #1;
        checks++;
        if ({st, error, halted} !== {exp_st, exp_err, !runs(op)}) begin
            errors++;
            $display("FAIL %s_end st/err/halt got=%0d/%b/%b exp=%0d/%b/%b",
                     name, st, error, halted, exp_st, exp_err, !runs(op));
        end
        checks++;
        if (cnt !== 32'(exp_count)) begin
            errors++;
            $display("FAIL %s_count got=%0d exp=%0d",
                     name, cnt, exp_count);
        end
        checks++;
        if (cnt3 !== 3'(sat3(exp_count))) begin
            errors++;
            $display("FAIL %s_count3 got=%0d exp=%0d",
                     name, cnt3, sat3(exp_count));
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        opcode = 7'd0;
        MemWrite = 1'b0;
        Zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_count = 0;
        #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        #1;
        checks++;
        if ({st, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL idle st/busy got=%0d/%b exp=0/0", st, busy);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        start_run();
        run_instr(ADD, 0, 0, 0, 0, "rst_add");
        opcode = LD;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        step();
        step();
        dmem_ready = 1'b0;
        #1;
        checks++;
        if ({st, mif.dmem_req} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL pre_rst st/dreq got=%0d/%b exp=4/1",
                     st, mif.dmem_req);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({mif.dmem_req, st, cnt, error} !== {1'b0, 3'd0, 32'd0, 1'b0})
        begin
            errors++;
            $display("FAIL async_rst dreq/st/cnt/err got=%b/%0d/%0d/%b",
                     mif.dmem_req, st, cnt, error);
        end
        step();
        reset = 1'b1;
        #1;
        checks++;
        if ({rw, pcw, ir, mif.dmem_req, mif.dmem_we, st} !== 8'd0) begin
            errors++;
            $display("FAIL release_quiet got=%b%b%b%b%b st=%0d exp=0",
                     rw, pcw, ir, mif.dmem_req, mif.dmem_we, st);
        end
        exp_count = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (st !== 3'd1) begin
            errors++;
            $display("FAIL start_fetch got=%0d exp=1", st);
        end
    endtask

    task automatic test_program();
        do_reset();
        start_run();
        run_instr(ADD, 0, 0, 0, 0, "prog_add");
        run_instr(LD, 0, 0, 0, 0, "prog_ld");
        run_instr(SD, 1, 0, 0, 0, "prog_sd");
        run_instr(BEQ, 0, 1, 0, 0, "prog_beq");
        run_instr(ECALL, 0, 0, 0, 0, "prog_ecall");
    endtask

    task automatic test_ld_wait();
        do_reset();
        start_run();
        run_instr(LD, 0, 0, 0, 3, "ld_wait");
        run_instr(BEQ, 0, 0, 0, 0, "ld_wait_beq0");
        run_instr(ECALL, 0, 0, 0, 0, "ld_wait_ecall");
    endtask

    task automatic test_illegal();
        do_reset();
        start_run();
        run_instr(ADD, 0, 0, 1, 0, "ill_add");
        run_instr(ADDI, 0, 0, 0, 0, "illegal");
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        checks++;
        if ({st, error, cnt} !== {3'd6, 1'b1, 32'd1}) begin
            errors++;
            $display("FAIL halt_sticky st/err/cnt got=%0d/%b/%0d",
                     st, error, cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        start_run();
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({st, mif.imem_req} !== {3'd1, 1'b1}) begin
                errors++;
                $display("FAIL fetch_wait%0d st/req got=%0d/%b exp=1/1",
                         i, st, mif.imem_req);
            end
            step();
        end
        checks++;
        if ({st, error, halted} !== {3'd6, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL imem_timeout st/err got=%0d/%b exp=6/1",
                     st, error);
        end
        do_reset();
        start_run();
        run_instr(ADD, 0, 0, 4, 0, "late_imem");
        run_instr(SD, 1, 0, 0, 4, "late_dmem");
        opcode = LD;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) step();
        checks++;
        if ({st, error, cnt} !== {3'd6, 1'b1, 32'd2}) begin
            errors++;
            $display("FAIL dmem_timeout st/err/cnt got=%0d/%b/%0d",
                     st, error, cnt);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [4];
        logic [6:0] op;
        ops[0] = ADD;
        ops[1] = LD;
        ops[2] = SD;
        ops[3] = BEQ;
        do_reset();
        start_run();
        for (int n = 0; n < 30; n++) begin
            op = ops[$urandom_range(0, 3)];
            run_instr(op, op == SD, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 4), $urandom_range(0, 4),
                      "rand");
        end
        run_instr(ECALL, 0, 0, $urandom_range(0, 2), 0, "rand_ecall");
    endtask

    task automatic test_saturate();
        do_reset();
        start_run();
        for (int n = 0; n < 9; n++) begin
            run_instr(ADD, 0, 0, $urandom_range(0, 2), 0, "sat_add");
        end
        run_instr(ECALL, 0, 0, 0, 0, "sat_ecall");
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if ({st, error, cnt, busy, halted} !== 38'd0) begin
            errors++;
            $display("FAIL reset_state st/err/cnt got=%0d/%b/%0d",
                     st, error, cnt);
        end
        test_reset();
        test_program();
        test_ld_wait();
        test_illegal();
        test_timeout();
        test_random();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
